// File: rtl/axi2apb_apb_master.sv
// Command-execution stage of the AXI-to-APB bridge: takes the command FIFO head,
// collects the W beat for writes, runs one APB3 transfer and returns the B or R response.
module axi2apb_apb_master #(
   parameter int AXI_ID_WIDTH   = 6,
   parameter int APB_ADDR_WIDTH = 12
) (
   input  logic                      clk,
   input  logic                      rstn,

   input  logic                      cmd_empty,
   input  logic                      cmd_read,
   input  logic [AXI_ID_WIDTH-1:0]   cmd_id,
   input  logic [APB_ADDR_WIDTH+3:0] cmd_addr,
   input  logic                      cmd_err,
   output logic                      finish_wr,
   output logic                      finish_rd,

   input  logic [31:0]               WDATA,
   input  logic [3:0]                WSTRB,
   input  logic                      WLAST,
   input  logic                      WVALID,
   output logic                      WREADY,

   output logic [AXI_ID_WIDTH-1:0]   BID,
   output logic [1:0]                BRESP,
   output logic                      BVALID,
   input  logic                      BREADY,

   output logic [AXI_ID_WIDTH-1:0]   RID,
   output logic [31:0]               RDATA,
   output logic [1:0]                RRESP,
   output logic                      RLAST,
   output logic                      RVALID,
   input  logic                      RREADY,

   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [15:0]               PSEL,
   output logic                      PENABLE,
   output logic                      PWRITE,
   output logic [31:0]               PWDATA,
   input  logic [31:0]               PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WDATA,
      ST_SETUP,
      ST_ACCESS,
      ST_BRESP,
      ST_RRESP
   } state_t;

   state_t                    state_reg, state_next;
   logic [15:0]               psel_reg, psel_next;
   logic                      penable_reg, penable_next;
   logic                      pwrite_reg, pwrite_next;
   logic [APB_ADDR_WIDTH-1:0] paddr_reg, paddr_next;
   logic [31:0]               pwdata_reg, pwdata_next;
   logic                      bvalid_reg, bvalid_next;
   logic [1:0]                bresp_reg, bresp_next;
   logic [AXI_ID_WIDTH-1:0]   bid_reg, bid_next;
   logic                      rvalid_reg, rvalid_next;
   logic                      rlast_reg, rlast_next;
   logic [1:0]                rresp_reg, rresp_next;
   logic [31:0]               rdata_reg, rdata_next;
   logic [AXI_ID_WIDTH-1:0]   rid_reg, rid_next;

   // Top nibble of the command address picks one of 16 APB slaves.
   logic [3:0]  slave_idx;
   logic [15:0] slave_sel;
   logic [1:0]  apb_resp;
   logic        unused_wstrb;

   assign slave_idx    = cmd_addr[APB_ADDR_WIDTH+3:APB_ADDR_WIDTH];
   assign apb_resp     = PSLVERR ? RESP_SLVERR : RESP_OKAY;
   assign unused_wstrb = ^WSTRB;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_slave_sel
         assign slave_sel[gi] = (slave_idx == 4'(gi));
      end
   endgenerate

   always_comb begin
      state_next   = state_reg;
      psel_next    = psel_reg;
      penable_next = penable_reg;
      pwrite_next  = pwrite_reg;
      paddr_next   = paddr_reg;
      pwdata_next  = pwdata_reg;
      bvalid_next  = bvalid_reg;
      bresp_next   = bresp_reg;
      bid_next     = bid_reg;
      rvalid_next  = rvalid_reg;
      rlast_next   = rlast_reg;
      rresp_next   = rresp_reg;
      rdata_next   = rdata_reg;
      rid_next     = rid_reg;

      case (state_reg)
         ST_IDLE: begin
            if (!cmd_empty) begin
               if (cmd_read && !cmd_err) begin
                  state_next   = ST_SETUP;
                  psel_next    = slave_sel;
                  paddr_next   = cmd_addr[APB_ADDR_WIDTH-1:0];
                  pwrite_next  = 1'b0;
                  penable_next = 1'b0;
               end else if (cmd_read) begin
                  // Unsupported read: answer immediately without touching APB.
                  state_next  = ST_RRESP;
                  rvalid_next = 1'b1;
                  rlast_next  = 1'b1;
                  rid_next    = cmd_id;
                  rresp_next  = RESP_SLVERR;
                  rdata_next  = '0;
               end else begin
                  state_next = ST_WDATA;
               end
            end
         end

         ST_WDATA: begin
            if (WVALID) begin
               pwdata_next = WDATA;
               if (cmd_err) begin
                  // Unsupported burst: swallow every beat up to WLAST, then error.
                  if (WLAST) begin
                     state_next  = ST_BRESP;
                     bvalid_next = 1'b1;
                     bid_next    = cmd_id;
                     bresp_next  = RESP_SLVERR;
                  end
               end else begin
                  state_next   = ST_SETUP;
                  psel_next    = slave_sel;
                  paddr_next   = cmd_addr[APB_ADDR_WIDTH-1:0];
                  pwrite_next  = 1'b1;
                  penable_next = 1'b0;
               end
            end
         end

         ST_SETUP: begin
            state_next   = ST_ACCESS;
            penable_next = 1'b1;
         end

         ST_ACCESS: begin
            if (PREADY) begin
               psel_next    = '0;
               penable_next = 1'b0;
               if (cmd_read) begin
                  state_next  = ST_RRESP;
                  rvalid_next = 1'b1;
                  rlast_next  = 1'b1;
                  rid_next    = cmd_id;
                  rresp_next  = apb_resp;
                  rdata_next  = PRDATA;
               end else begin
                  state_next  = ST_BRESP;
                  bvalid_next = 1'b1;
                  bid_next    = cmd_id;
                  bresp_next  = apb_resp;
               end
            end
         end

         ST_BRESP: begin
            if (BREADY) begin
               state_next  = ST_IDLE;
               bvalid_next = 1'b0;
            end
         end

         ST_RRESP: begin
            if (RREADY) begin
               state_next  = ST_IDLE;
               rvalid_next = 1'b0;
               rlast_next  = 1'b0;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg   <= ST_IDLE;
         psel_reg    <= '0;
         penable_reg <= 1'b0;
         pwrite_reg  <= 1'b0;
         paddr_reg   <= '0;
         pwdata_reg  <= '0;
         bvalid_reg  <= 1'b0;
         bresp_reg   <= '0;
         bid_reg     <= '0;
         rvalid_reg  <= 1'b0;
         rlast_reg   <= 1'b0;
         rresp_reg   <= '0;
         rdata_reg   <= '0;
         rid_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         psel_reg    <= psel_next;
         penable_reg <= penable_next;
         pwrite_reg  <= pwrite_next;
         paddr_reg   <= paddr_next;
         pwdata_reg  <= pwdata_next;
         bvalid_reg  <= bvalid_next;
         bresp_reg   <= bresp_next;
         bid_reg     <= bid_next;
         rvalid_reg  <= rvalid_next;
         rlast_reg   <= rlast_next;
         rresp_reg   <= rresp_next;
         rdata_reg   <= rdata_next;
         rid_reg     <= rid_next;
      end
   end

   assign WREADY    = (state_reg == ST_WDATA);
   assign finish_wr = bvalid_reg & BREADY;
   assign finish_rd = rvalid_reg & RREADY;

   assign PSEL    = psel_reg;
   assign PENABLE = penable_reg;
   assign PWRITE  = pwrite_reg;
   assign PADDR   = paddr_reg;
   assign PWDATA  = pwdata_reg;
   assign BVALID  = bvalid_reg;
   assign BRESP   = bresp_reg;
   assign BID     = bid_reg;
   assign RVALID  = rvalid_reg;
   assign RLAST   = rlast_reg;
   assign RRESP   = rresp_reg;
   assign RDATA   = rdata_reg;
   assign RID     = rid_reg;

endmodule

// File: doc/axi2apb_apb_master.md
Name: axi2apb_apb_master

Overview:
- Command-execution stage of the AXI-to-APB bridge, fed by the bridge's command FIFO head (cmd_empty/cmd_read/cmd_id/cmd_addr/cmd_err).
- For each queued command it accepts the AXI W beat (writes), runs one APB SETUP/ACCESS transfer, and returns the AXI B or R response.
- finish_wr/finish_rd pulses pop the command FIFO; those pulses are the only feedback path to the command stage.

Parameters:
- AXI_ID_WIDTH, 6, width of cmd_id/BID/RID
- APB_ADDR_WIDTH, 12, APB address width per slave; cmd_addr is APB_ADDR_WIDTH+4 bits

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- cmd_empty  in  1  command FIFO empty
- cmd_read  in  1  head command is a read
- cmd_id  in  AXI_ID_WIDTH  head command ID
- cmd_addr  in  APB_ADDR_WIDTH+4  head command address; top 4 bits = slave select
- cmd_err  in  1  head command unsupported (size!=4B or len!=0)
- finish_wr  out  1  write command complete (pops FIFO)
- finish_rd  out  1  read command complete (pops FIFO)
- WDATA  in  32  AXI write data
- WSTRB  in  4  AXI write strobes (ignored; APB3 has no strobes)
- WLAST  in  1  last W beat
- WVALID  in  1  W valid
- WREADY  out  1  W ready
- BID  out  AXI_ID_WIDTH  write response ID
- BRESP  out  2  write response
- BVALID  out  1  B valid
- BREADY  in  1  B ready
- RID  out  AXI_ID_WIDTH  read response ID
- RDATA  out  32  read data
- RRESP  out  2  read response
- RLAST  out  1  always 1 while RVALID
- RVALID  out  1  R valid
- RREADY  in  1  R ready
- PADDR  out  APB_ADDR_WIDTH  APB address
- PSEL  out  16  one-hot slave select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- Reset (rstn=0 at clk edge, synchronous): state=IDLE; all outputs 0, including PSEL, PENABLE, WREADY, BVALID, RVALID, PADDR, PWDATA, RDATA, BRESP, RRESP, BID, RID. Reset mid-transfer aborts immediately; no response is issued and the FIFO is not popped.
- All outputs are registered except finish_wr=BVALID&BREADY, finish_rd=RVALID&RREADY, and WREADY (decoded from state).
- States: IDLE, WDATA, SETUP, ACCESS, BRESP, RRESP.
- IDLE:
  - if cmd_empty, stay.
  - else if cmd_read & !cmd_err, go to SETUP.
  - else if cmd_read & cmd_err, go to RRESP with RRESP=2'b10, RDATA=0.
  - else (write), go to WDATA.
- WDATA: WREADY=1.
  - On WVALID, capture WDATA into PWDATA.
  - If cmd_err: stay until the beat with WLAST=1 is accepted (drain all beats), then go to BRESP with BRESP=2'b10.
  - If !cmd_err: the first accepted beat goes to SETUP regardless of WLAST.
- SETUP: PSEL[cmd_addr[APB_ADDR_WIDTH+3:APB_ADDR_WIDTH]]=1, PADDR=cmd_addr[APB_ADDR_WIDTH-1:0], PWRITE=!cmd_read, PENABLE=0. Exactly one cycle, then ACCESS.
- ACCESS: PENABLE=1; PSEL, PADDR, PWRITE and PWDATA held stable.
  - Waits indefinitely while PREADY=0; no timeout.
  - On PREADY=1: PSEL and PENABLE go to 0 next cycle; capture PRDATA into RDATA on reads; response = PSLVERR ? 2'b10 : 2'b00; go to BRESP or RRESP.
- BRESP/RRESP: VALID held with BID/RID=cmd_id, and data/resp stable, until READY. The handshake cycle pulses finish_* for exactly one cycle, and VALID drops next cycle, returning to IDLE.
- The FIFO head advances after the pop, so IDLE samples the next command no earlier than the cycle after the finish pulse. There is no back-to-back overlap and at most one command is in flight.
- Minimum latency:
  - write with WVALID already high: IDLE→WDATA→SETUP→ACCESS→BRESP, i.e. BVALID 4 cycles after cmd_empty falls, with PREADY=1.
  - read: BVALID/RVALID counterpart is RVALID 3 cycles after cmd_empty falls.
- cmd_id, cmd_addr, cmd_read and cmd_err are stable until the pop and are used directly; they are not re-latched.
- The pulses are mutually exclusive: finish_wr and finish_rd never assert in the same cycle.

Test Plan:
- Write: cmd addr=0x3_010, WDATA=0xDEADBEEF, PREADY=1 → PSEL=16'h0008, PADDR=0x010, PWRITE=1, one SETUP + one ACCESS cycle; BVALID, BRESP=00, BID=cmd_id; finish_wr pulse 1 cycle.
- Read with wait states: slave 0xF, PREADY low 3 cycles, PRDATA=0x12345678 → PENABLE high 4 cycles, RDATA=0x12345678, RRESP=00, RLAST=1, finish_rd 1 cycle.
- Error write: cmd_err=1 with 4 W beats (WLAST on 4th) → PSEL stays 0, WREADY for all 4 beats, then BRESP=10, finish_wr.
- PSLVERR=1 on read plus RREADY held low 5 cycles → RRESP=10, RVALID/RDATA stable 5 cycles, finish_rd only on the handshake.
- Reset asserted in ACCESS → next cycle PSEL=0, PENABLE=0, no BVALID, finish_* never pulsed; a new command is served normally afterwards.
- Back-to-back write then read queued → read SETUP starts no earlier than 2 cycles after finish_wr; the finish pulses never overlap.
